// File: rtl/op_centric_deque_tagged.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : op_centric_deque_tagged                                        |
// | Brief   : Tagged double-ended queue with six operation ports, a          |
// |           lowest-free tag pool, CAM-based update/delete by tag and       |
// |           one committed operation per cycle.                             |
// | Option  : OCQ_RR_ARB_EN selects round-robin arbitration. When it is not  |
// |           defined, fixed priority applies:                               |
// |           del > upd > deq_front > deq_back > enq_front > enq_back.       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module op_centric_deque_tagged #(
  parameter int p_depth     = 8,
  parameter int p_chanwidth = 32,
  parameter int p_ptrwidth  = $clog2(p_depth)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enq_back_en,
  input  logic [p_chanwidth-1:0] enq_back_data,
  output logic                   enq_back_cpl,
  output logic [p_ptrwidth-1:0]  enq_back_tag_out,
  input  logic                   enq_front_en,
  input  logic [p_chanwidth-1:0] enq_front_data,
  output logic                   enq_front_cpl,
  output logic [p_ptrwidth-1:0]  enq_front_tag_out,
  input  logic                   deq_front_en,
  output logic                   deq_front_cpl,
  output logic [p_chanwidth-1:0] deq_front_data,
  input  logic                   deq_back_en,
  output logic                   deq_back_cpl,
  output logic [p_chanwidth-1:0] deq_back_data,
  input  logic                   upd_en,
  input  logic [p_ptrwidth-1:0]  upd_tag_in,
  input  logic [p_chanwidth-1:0] upd_data_in,
  output logic                   upd_cpl,
  output logic                   upd_err,
  input  logic                   del_en,
  input  logic [p_ptrwidth-1:0]  del_tag_in,
  output logic                   del_cpl,
  output logic                   del_err,
  output logic [p_ptrwidth:0]    count,
  output logic                   full,
  output logic                   empty
);

  // Port indices, also the fixed-priority order (lower index wins)
  localparam logic [2:0] c_del       = 3'd0;
  localparam logic [2:0] c_upd       = 3'd1;
  localparam logic [2:0] c_deq_front = 3'd2;
  localparam logic [2:0] c_deq_back  = 3'd3;
  localparam logic [2:0] c_enq_front = 3'd4;
  localparam logic [2:0] c_enq_back  = 3'd5;
  localparam int         c_nports    = 6;

  localparam logic [p_ptrwidth:0] c_depth_cnt = (p_ptrwidth+1)'(p_depth);
  localparam logic [p_ptrwidth:0] c_one       = (p_ptrwidth+1)'(1);

  // Ordered slot storage; slot 0 is the front, valid entries are compacted low
  logic [p_ptrwidth-1:0]  r_tag  [p_depth];
  logic [p_chanwidth-1:0] r_data [p_depth];
  logic [p_depth-1:0]     r_occ;
  logic [p_depth-1:0]     r_free;

  logic [p_ptrwidth-1:0]  w_nxt_tag  [p_depth];
  logic [p_chanwidth-1:0] w_nxt_data [p_depth];
  logic [p_depth-1:0]     w_nxt_occ;
  logic [p_depth-1:0]     w_nxt_free;
  logic [p_ptrwidth:0]    w_nxt_count;

  logic [c_nports-1:0]    w_req;
  logic                   w_any;
  logic [2:0]             w_win;
  logic [p_ptrwidth-1:0]  w_cam_tag;
  logic [p_ptrwidth-1:0]  w_hit_idx;
  logic                   w_hit;
  logic [p_ptrwidth-1:0]  w_alloc_tag;
  logic [p_ptrwidth-1:0]  w_back_tag;
  logic [p_chanwidth-1:0] w_back_data;

  // A port whose cpl is currently high sits out this cycle's arbitration
  assign w_req = {enq_back_en  & ~enq_back_cpl  & ~full,
                  enq_front_en & ~enq_front_cpl & ~full,
                  deq_back_en  & ~deq_back_cpl  & ~empty,
                  deq_front_en & ~deq_front_cpl & ~empty,
                  upd_en       & ~upd_cpl,
                  del_en       & ~del_cpl};
  assign w_any = |w_req;

`ifdef OCQ_RR_ARB_EN
  logic [2:0] r_rr_ptr;
  logic [3:0] w_sum;

  // Round-robin: first requester at or after the rotating pointer
  always_comb begin
    w_win = c_del;
    w_sum = '0;
    for (int k = c_nports-1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(k);
      if (w_sum >= 4'(c_nports)) w_sum = w_sum - 4'(c_nports);
      if (w_req[w_sum[2:0]]) w_win = w_sum[2:0];
    end
  end

  // Pointer moves to one past the last winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rr_ptr <= c_del;
    else if (w_any) r_rr_ptr <= (w_win == c_enq_back) ? c_del : w_win + 3'd1;
  end
`else
  // Fixed priority: lowest requesting index wins
  always_comb begin
    w_win = c_del;
    for (int k = c_nports-1; k >= 0; k--) begin
      if (w_req[k]) w_win = 3'(k);
    end
  end
`endif

  // Tag CAM over occupied slots, lowest-free tag pick and back-slot read
  always_comb begin
    w_cam_tag = (w_win == c_del) ? del_tag_in : upd_tag_in;
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = p_depth-1; i >= 0; i--) begin
      if (r_occ[i] && (r_tag[i] == w_cam_tag)) begin
        w_hit     = 1'b1;
        w_hit_idx = p_ptrwidth'(i);
      end
    end
    w_alloc_tag = '0;
    for (int i = p_depth-1; i >= 0; i--) begin
      if (r_free[i]) w_alloc_tag = p_ptrwidth'(i);
    end
    w_back_tag  = '0;
    w_back_data = '0;
    for (int i = 0; i < p_depth; i++) begin
      if ((p_ptrwidth+1)'(i) == count - c_one) begin
        w_back_tag  = r_tag[i];
        w_back_data = r_data[i];
      end
    end
  end

  // Next slot contents, tag pool and count for the winning operation
  always_comb begin
    for (int i = 0; i < p_depth; i++) begin
      w_nxt_tag[i]  = r_tag[i];
      w_nxt_data[i] = r_data[i];
    end
    w_nxt_free  = r_free;
    w_nxt_count = count;
    if (w_any) begin
      case (w_win)
        c_del: begin
          if (w_hit) begin
            for (int i = 0; i < p_depth-1; i++) begin
              if (p_ptrwidth'(i) >= w_hit_idx) begin
                w_nxt_tag[i]  = r_tag[i+1];
                w_nxt_data[i] = r_data[i+1];
              end
            end
            w_nxt_tag[p_depth-1]  = '0;
            w_nxt_data[p_depth-1] = '0;
            w_nxt_free[w_cam_tag] = 1'b1;
            w_nxt_count           = count - c_one;
          end
        end
        c_upd: begin
          if (w_hit) w_nxt_data[w_hit_idx] = upd_data_in;
        end
        c_deq_front: begin
          for (int i = 0; i < p_depth-1; i++) begin
            w_nxt_tag[i]  = r_tag[i+1];
            w_nxt_data[i] = r_data[i+1];
          end
          w_nxt_tag[p_depth-1]  = '0;
          w_nxt_data[p_depth-1] = '0;
          w_nxt_free[r_tag[0]]  = 1'b1;
          w_nxt_count           = count - c_one;
        end
        c_deq_back: begin
          for (int i = 0; i < p_depth; i++) begin
            if ((p_ptrwidth+1)'(i) == count - c_one) begin
              w_nxt_tag[i]  = '0;
              w_nxt_data[i] = '0;
            end
          end
          w_nxt_free[w_back_tag] = 1'b1;
          w_nxt_count            = count - c_one;
        end
        c_enq_front: begin
          for (int i = p_depth-1; i > 0; i--) begin
            w_nxt_tag[i]  = r_tag[i-1];
            w_nxt_data[i] = r_data[i-1];
          end
          w_nxt_tag[0]            = w_alloc_tag;
          w_nxt_data[0]           = enq_front_data;
          w_nxt_free[w_alloc_tag] = 1'b0;
          w_nxt_count             = count + c_one;
        end
        c_enq_back: begin
          for (int i = 0; i < p_depth; i++) begin
            if ((p_ptrwidth+1)'(i) == count) begin
              w_nxt_tag[i]  = w_alloc_tag;
              w_nxt_data[i] = enq_back_data;
            end
          end
          w_nxt_free[w_alloc_tag] = 1'b0;
          w_nxt_count             = count + c_one;
        end
        default: ;
      endcase
    end
    for (int i = 0; i < p_depth; i++) begin
      w_nxt_occ[i] = ((p_ptrwidth+1)'(i) < w_nxt_count);
    end
  end

  // Commit state and register the winner's completion, error and result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < p_depth; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
      r_occ             <= '0;
      r_free            <= '1;
      count             <= '0;
      full              <= 1'b0;
      empty             <= 1'b1;
      enq_back_cpl      <= 1'b0;
      enq_front_cpl     <= 1'b0;
      deq_front_cpl     <= 1'b0;
      deq_back_cpl      <= 1'b0;
      upd_cpl           <= 1'b0;
      del_cpl           <= 1'b0;
      upd_err           <= 1'b0;
      del_err           <= 1'b0;
      enq_back_tag_out  <= '0;
      enq_front_tag_out <= '0;
      deq_front_data    <= '0;
      deq_back_data     <= '0;
    end else begin
      for (int i = 0; i < p_depth; i++) begin
        r_tag[i]  <= w_nxt_tag[i];
        r_data[i] <= w_nxt_data[i];
      end
      r_occ         <= w_nxt_occ;
      r_free        <= w_nxt_free;
      count         <= w_nxt_count;
      full          <= (w_nxt_count == c_depth_cnt);
      empty         <= (w_nxt_count == '0);
      enq_back_cpl  <= 1'b0;
      enq_front_cpl <= 1'b0;
      deq_front_cpl <= 1'b0;
      deq_back_cpl  <= 1'b0;
      upd_cpl       <= 1'b0;
      del_cpl       <= 1'b0;
      upd_err       <= 1'b0;
      del_err       <= 1'b0;
      if (w_any) begin
        case (w_win)
          c_del: begin
            del_cpl <= 1'b1;
            del_err <= ~w_hit;
          end
          c_upd: begin
            upd_cpl <= 1'b1;
            upd_err <= ~w_hit;
          end
          c_deq_front: begin
            deq_front_cpl  <= 1'b1;
            deq_front_data <= r_data[0];
          end
          c_deq_back: begin
            deq_back_cpl  <= 1'b1;
            deq_back_data <= w_back_data;
          end
          c_enq_front: begin
            enq_front_cpl     <= 1'b1;
            enq_front_tag_out <= w_alloc_tag;
          end
          c_enq_back: begin
            enq_back_cpl     <= 1'b1;
            enq_back_tag_out <= w_alloc_tag;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_op_centric_deque_tagged.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_op_centric_deque_tagged                                     |
// | Brief   : Self-checking bench for op_centric_deque_tagged (depth 4):     |
// |           vector table, hand-written corner sequences and random single- |
// |           port operations against a queue-based reference model.         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_op_centric_deque_tagged;

  localparam int DEPTH = 4;
  localparam int CW    = 32;
  localparam int PW    = 2;

  localparam int OP_DEL = 0;
  localparam int OP_UPD = 1;
  localparam int OP_DQF = 2;
  localparam int OP_DQB = 3;
  localparam int OP_EQF = 4;
  localparam int OP_EQB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enq_back_en = 1'b0, enq_front_en = 1'b0;
  logic          deq_front_en = 1'b0, deq_back_en = 1'b0;
  logic          upd_en = 1'b0, del_en = 1'b0;
  logic [CW-1:0] enq_back_data = '0, enq_front_data = '0, upd_data_in = '0;
  logic [PW-1:0] upd_tag_in = '0, del_tag_in = '0;
  logic          enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl;
  logic          upd_cpl, upd_err, del_cpl, del_err;
  logic [PW-1:0] enq_back_tag_out, enq_front_tag_out;
  logic [CW-1:0] deq_front_data, deq_back_data;
  logic [PW:0]   count;
  logic          full, empty;

  always #5 clk = ~clk;

  op_centric_deque_tagged #(.p_depth(DEPTH), .p_chanwidth(CW)) dut (
    .clk(clk), .rst(rst),
    .enq_back_en(enq_back_en), .enq_back_data(enq_back_data),
    .enq_back_cpl(enq_back_cpl), .enq_back_tag_out(enq_back_tag_out),
    .enq_front_en(enq_front_en), .enq_front_data(enq_front_data),
    .enq_front_cpl(enq_front_cpl), .enq_front_tag_out(enq_front_tag_out),
    .deq_front_en(deq_front_en), .deq_front_cpl(deq_front_cpl), .deq_front_data(deq_front_data),
    .deq_back_en(deq_back_en), .deq_back_cpl(deq_back_cpl), .deq_back_data(deq_back_data),
    .upd_en(upd_en), .upd_tag_in(upd_tag_in), .upd_data_in(upd_data_in),
    .upd_cpl(upd_cpl), .upd_err(upd_err),
    .del_en(del_en), .del_tag_in(del_tag_in), .del_cpl(del_cpl), .del_err(del_err),
    .count(count), .full(full), .empty(empty)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference model: ordered queue of entries plus a free-tag array
  int          m_tag[$];
  logic [31:0] m_data[$];
  bit          m_free[DEPTH];

  function automatic void m_reset();
    m_tag.delete();
    m_data.delete();
    for (int i = 0; i < DEPTH; i++) m_free[i] = 1'b1;
  endfunction

  function automatic int m_alloc();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_free[i]) begin
        m_free[i] = 1'b0;
        return i;
      end
    end
    return -1;
  endfunction

  task automatic m_apply(input int op, input logic [31:0] d, input int tg,
                         output logic [31:0] val, output logic err);
    int idx;
    int t;
    val = '0;
    err = 1'b0;
    idx = -1;
    case (op)
      OP_DEL, OP_UPD: begin
        foreach (m_tag[i]) if (m_tag[i] == tg) idx = i;
        if (idx < 0) err = 1'b1;
        else if (op == OP_UPD) m_data[idx] = d;
        else begin
          m_free[tg] = 1'b1;
          m_tag.delete(idx);
          m_data.delete(idx);
        end
      end
      OP_DQF: begin
        val = m_data.pop_front();
        t = m_tag.pop_front();
        m_free[t] = 1'b1;
      end
      OP_DQB: begin
        val = m_data.pop_back();
        t = m_tag.pop_back();
        m_free[t] = 1'b1;
      end
      OP_EQF: begin
        t = m_alloc();
        m_tag.push_front(t);
        m_data.push_front(d);
        val = 32'(t);
      end
      default: begin
        t = m_alloc();
        m_tag.push_back(t);
        m_data.push_back(d);
        val = 32'(t);
      end
    endcase
  endtask

  // Issue one operation on one port and wait (bounded) for its completion
  task automatic do_op(input int op, input logic [31:0] d, input int tg,
                       output logic [31:0] val, output logic err, output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    val  = '0;
    err  = 1'b0;
    @(negedge clk);
    case (op)
      OP_DEL: begin del_tag_in = PW'(tg); del_en = 1'b1; end
      OP_UPD: begin upd_tag_in = PW'(tg); upd_data_in = d; upd_en = 1'b1; end
      OP_DQF: deq_front_en = 1'b1;
      OP_DQB: deq_back_en = 1'b1;
      OP_EQF: begin enq_front_data = d; enq_front_en = 1'b1; end
      default: begin enq_back_data = d; enq_back_en = 1'b1; end
    endcase
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      case (op)
        OP_DEL:  seen = del_cpl;
        OP_UPD:  seen = upd_cpl;
        OP_DQF:  seen = deq_front_cpl;
        OP_DQB:  seen = deq_back_cpl;
        OP_EQF:  seen = enq_front_cpl;
        default: seen = enq_back_cpl;
      endcase
    end
    case (op)
      OP_DEL:  err = del_err;
      OP_UPD:  err = upd_err;
      OP_DQF:  val = deq_front_data;
      OP_DQB:  val = deq_back_data;
      OP_EQF:  val = 32'(enq_front_tag_out);
      default: val = 32'(enq_back_tag_out);
    endcase
    {del_en, upd_en, deq_front_en, deq_back_en, enq_front_en, enq_back_en} = '0;
    chk($sformatf("op%0d cpl", op), 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    {del_en, upd_en, deq_front_en, deq_back_en, enq_front_en, enq_back_en} = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  typedef struct {
    int          op;
    logic [31:0] d;
    int          tg;
    logic [31:0] exp_val;
    logic        exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[18];

  logic [31:0] val, mval;
  logic        err, merr;
  int          cyc;
  int          t_del, t_upd, t_dqf, t_eqb;
  logic [31:0] s_dq, s_tag;
  logic        s_de, s_ue;

  initial begin
    tbl[0]  = '{OP_EQB, 32'hA,  0, 32'd0,  1'b0, 1};
    tbl[1]  = '{OP_EQB, 32'hB,  0, 32'd1,  1'b0, 2};
    tbl[2]  = '{OP_EQB, 32'hC,  0, 32'd2,  1'b0, 3};
    tbl[3]  = '{OP_DQF, 32'h0,  0, 32'hA,  1'b0, 2};
    tbl[4]  = '{OP_DQB, 32'h0,  0, 32'hC,  1'b0, 1};
    tbl[5]  = '{OP_DQF, 32'h0,  0, 32'hB,  1'b0, 0};
    tbl[6]  = '{OP_EQB, 32'h10, 0, 32'd0,  1'b0, 1};
    tbl[7]  = '{OP_EQB, 32'h20, 0, 32'd1,  1'b0, 2};
    tbl[8]  = '{OP_EQB, 32'h30, 0, 32'd2,  1'b0, 3};
    tbl[9]  = '{OP_DEL, 32'h0,  1, 32'd0,  1'b0, 2};
    tbl[10] = '{OP_DQF, 32'h0,  0, 32'h10, 1'b0, 1};
    tbl[11] = '{OP_DQF, 32'h0,  0, 32'h30, 1'b0, 0};
    tbl[12] = '{OP_UPD, 32'h5,  1, 32'd0,  1'b1, 0};
    tbl[13] = '{OP_UPD, 32'h5,  0, 32'd0,  1'b1, 0};
    tbl[14] = '{OP_EQF, 32'h55, 0, 32'd0,  1'b0, 1};
    tbl[15] = '{OP_UPD, 32'h66, 0, 32'd0,  1'b0, 1};
    tbl[16] = '{OP_DQB, 32'h0,  0, 32'h66, 1'b0, 0};
    tbl[17] = '{OP_DEL, 32'h0,  3, 32'd0,  1'b1, 0};

    // Reset state
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst count", 32'(count), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst cpl/err", 32'({enq_back_cpl, enq_front_cpl, deq_front_cpl, deq_back_cpl,
                            upd_cpl, del_cpl, upd_err, del_err}), 32'd0);
    chk("rst outputs", 32'(deq_front_data | deq_back_data |
                           32'({enq_back_tag_out, enq_front_tag_out})), 32'd0);
    rst = 1'b1;

    // Vector table
    foreach (tbl[i]) begin
      do_op(tbl[i].op, tbl[i].d, tbl[i].tg, val, err, cyc);
      if (tbl[i].op == OP_DEL || tbl[i].op == OP_UPD)
        chk($sformatf("vec%0d err", i), 32'(err), 32'(tbl[i].exp_err));
      else
        chk($sformatf("vec%0d value", i), val, tbl[i].exp_val);
      chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d latency", i), 32'(cyc), 32'd1);
    end
    @(negedge clk);
    chk("err clears", 32'({del_cpl, del_err}), 32'd0);

    // Full: pending enq stalls until a deq frees a tag one edge earlier
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      do_op(OP_EQF, 32'(i), 0, val, err, cyc);
      chk($sformatf("fill tag%0d", i), val, 32'(i-1));
    end
    chk("fill full", 32'(full), 32'd1);
    @(negedge clk);
    enq_back_data = 32'h5;
    enq_back_en   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall no cpl", 32'(enq_back_cpl), 32'd0);
    end
    deq_front_en = 1'b1;
    @(negedge clk);
    deq_front_en = 1'b0;
    chk("stall deq cpl", 32'(deq_front_cpl), 32'd1);
    chk("stall deq data", deq_front_data, 32'h4);
    chk("stall enq not same edge", 32'(enq_back_cpl), 32'd0);
    @(negedge clk);
    enq_back_en = 1'b0;
    chk("stall enq cpl", 32'(enq_back_cpl), 32'd1);
    chk("stall enq tag", 32'(enq_back_tag_out), 32'd3);
    chk("stall full again", 32'(full), 32'd1);

    // Asynchronous reset while an enq is pending
    @(negedge clk);
    enq_back_data = 32'h9;
    enq_back_en   = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst count", 32'(count), 32'd0);
    chk("arst empty/full", 32'({empty, full}), 32'b10);
    chk("arst tag out", 32'(enq_back_tag_out), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("arst no cpl", 32'(enq_back_cpl), 32'd0);
    end
    enq_back_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    do_op(OP_EQB, 32'h42, 0, val, err, cyc);
    chk("arst first tag", val, 32'd0);
    chk("arst count1", 32'(count), 32'd1);

    // Four ports requesting in the same cycle
    do_reset();
    do_op(OP_EQB, 32'h11, 0, val, err, cyc);
    do_op(OP_EQB, 32'h22, 0, val, err, cyc);
    t_del = -1; t_upd = -1; t_dqf = -1; t_eqb = -1;
    s_dq = '0; s_tag = '0; s_de = 1'b1; s_ue = 1'b1;
    @(negedge clk);
    del_tag_in = 2'd0; del_en = 1'b1;
    upd_tag_in = 2'd1; upd_data_in = 32'h99; upd_en = 1'b1;
    deq_front_en = 1'b1;
    enq_back_data = 32'h77; enq_back_en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (del_cpl)       begin t_del = c; s_de = del_err; del_en = 1'b0; end
      if (upd_cpl)       begin t_upd = c; s_ue = upd_err; upd_en = 1'b0; end
      if (deq_front_cpl) begin t_dqf = c; s_dq = deq_front_data; deq_front_en = 1'b0; end
      if (enq_back_cpl)  begin t_eqb = c; s_tag = 32'(enq_back_tag_out); enq_back_en = 1'b0; end
    end
    {del_en, upd_en, deq_front_en, enq_back_en} = '0;
`ifdef OCQ_RR_ARB_EN
    chk("rr del bound", 32'(t_del >= 1 && t_del <= 6), 32'd1);
    chk("rr upd bound", 32'(t_upd >= 1 && t_upd <= 6), 32'd1);
    chk("rr dqf bound", 32'(t_dqf >= 1 && t_dqf <= 6), 32'd1);
    chk("rr eqb bound", 32'(t_eqb >= 1 && t_eqb <= 6), 32'd1);
`else
    chk("prio del cycle", 32'(t_del), 32'd1);
    chk("prio upd cycle", 32'(t_upd), 32'd2);
    chk("prio dqf cycle", 32'(t_dqf), 32'd3);
    chk("prio eqb cycle", 32'(t_eqb), 32'd4);
    chk("prio errs", 32'({s_de, s_ue}), 32'd0);
    chk("prio deq data", s_dq, 32'h99);
    chk("prio enq tag", s_tag, 32'd0);
`endif
    chk("prio count", 32'(count), 32'd1);

    // Random single-port operations against the reference model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int op;
      int tg;
      logic [31:0] d;
      op = int'($urandom_range(0, 5));
      tg = int'($urandom_range(0, DEPTH-1));
      d  = $urandom;
      if ((op == OP_EQF || op == OP_EQB) && m_tag.size() == DEPTH) op = OP_DQF;
      if ((op == OP_DQF || op == OP_DQB) && m_tag.size() == 0) op = OP_EQB;
      do_op(op, d, tg, val, err, cyc);
      m_apply(op, d, tg, mval, merr);
      if (op == OP_DEL || op == OP_UPD)
        chk($sformatf("rnd%0d op%0d err", n, op), 32'(err), 32'(merr));
      else
        chk($sformatf("rnd%0d op%0d value", n, op), val, mval);
      chk($sformatf("rnd%0d count", n), 32'(count), 32'(m_tag.size()));
      chk($sformatf("rnd%0d full/empty", n), 32'({full, empty}),
          32'({m_tag.size() == DEPTH, m_tag.size() == 0}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
